// File: rtl/cpa_seg_seq.sv
// Sequential segmented carry-propagate adder: sums two WIDTH-bit carry-save rows SEG_W bits per cycle.
// Optional macro CPA_EARLY_DONE_EN stops early once the carry dies and no nonzero operand bits remain.
module cpa_seg_seq #(
   parameter int WIDTH = 2093,
   parameter int SEG_W = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum_out,
   output logic             busy
`ifdef CPA_EARLY_DONE_EN
   ,
   output logic [7:0]       segs_used
`endif
);

   localparam int NUM_SEGS = (WIDTH + SEG_W - 1) / SEG_W;
   localparam int LAST_W   = WIDTH - (NUM_SEGS - 1) * SEG_W;
   localparam int CNT_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
   localparam int SH_W     = $clog2(NUM_SEGS * SEG_W + 1) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_lo;
   logic             sum_top;
   logic             carry;
   logic [CNT_W-1:0] seg_cnt;

   logic [SH_W-1:0]  shamt;
   logic [SEG_W-1:0] a_seg;
   logic [SEG_W-1:0] b_seg;
   logic [SEG_W:0]   seg_res;
   logic             is_last;
   logic             carry_out;
   logic [WIDTH-1:0] seg_mask;
   logic [WIDTH-1:0] sum_next;

   assign in_ready  = (state == ST_IDLE) && !reset;
   assign busy      = (state == ST_RUN);
   assign out_valid = (state == ST_DONE);
   assign sum_out   = {sum_top, sum_lo};

   // The segment is picked by shifting the whole operand; bits past WIDTH read as zero,
   // so the short last segment naturally arrives zero-padded.
   always_comb begin
      shamt     = SH_W'(seg_cnt) * SH_W'(SEG_W);
      a_seg     = SEG_W'(op_a >> shamt);
      b_seg     = SEG_W'(op_b >> shamt);
      seg_res   = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_W+1)'(carry);
      is_last   = (seg_cnt == CNT_W'(NUM_SEGS - 1));
      // The last segment is only LAST_W bits wide, so its carry sits at bit LAST_W.
      carry_out = is_last ? seg_res[LAST_W] : seg_res[SEG_W];
      seg_mask  = WIDTH'({SEG_W{1'b1}}) << shamt;
      sum_next  = (sum_lo & ~seg_mask) | (WIDTH'(seg_res[SEG_W-1:0]) << shamt);
   end

`ifdef CPA_EARLY_DONE_EN
   logic [SH_W-1:0]  hi_sh;
   logic             above_zero;
   logic [WIDTH-1:0] keep_mask;
   logic             early_exit;

   // Everything from the next segment upward is zero in both operands and no carry is pending,
   // so the remaining sum bits are known to be zero.
   always_comb begin
      hi_sh      = shamt + SH_W'(SEG_W);
      above_zero = (((op_a | op_b) >> hi_sh) == '0);
      keep_mask  = ~({WIDTH{1'b1}} << hi_sh);
      early_exit = !carry_out && above_zero && !is_last;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         sum_lo  <= '0;
         sum_top <= 1'b0;
         carry   <= 1'b0;
         seg_cnt <= '0;
`ifdef CPA_EARLY_DONE_EN
         segs_used <= 8'd0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_a    <= a_in;
                  op_b    <= b_in;
                  carry   <= 1'b0;
                  seg_cnt <= '0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               carry   <= carry_out;
               seg_cnt <= seg_cnt + CNT_W'(1);
               sum_lo  <= sum_next;
               if (is_last) begin
                  sum_top <= carry_out;
                  state   <= ST_DONE;
`ifdef CPA_EARLY_DONE_EN
                  segs_used <= 8'(seg_cnt) + 8'd1;
               end else if (early_exit) begin
                  sum_lo    <= sum_next & keep_mask;
                  sum_top   <= 1'b0;
                  state     <= ST_DONE;
                  segs_used <= 8'(seg_cnt) + 8'd1;
`endif
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
